// File: rtl/mult_share_sched_if.sv
// Requester/result bundle for the shared multiplier scheduler.
// slave = scheduler side, master = requesters plus result consumer.
interface mult_share_sched_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    localparam int ID_W = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1;

    logic                   en;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*WIDTH-1:0]     res_data;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    modport slave (
        input  en, req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );

    modport master (
        output en, req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one WIDTH-stage pipelined radix-2 Booth multiplier
// among N_REQ requesters; tagged results return in issue order through a credit-guarded FIFO.
module mult_share_sched #(
    parameter int WIDTH      = 8,
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_share_sched_if.slave bus
);
    localparam int ID_W  = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + WIDTH + 2);

    logic                init_q, init_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     cand;
    logic                issue;
    logic [N_REQ-1:0]    req_ready;
    logic [WIDTH-1:0]    mul_a, mul_b;
    logic [OCC_W-1:0]    inflight, used;

    logic [WIDTH-1:0]    tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]     tag_id_q [WIDTH];
    logic [ID_W-1:0]     tag_id_d [WIDTH];

    logic [PW-1:0]       acc_q [WIDTH];
    logic [PW-1:0]       acc_d [WIDTH];
    logic [WIDTH-1:0]    opa_q [WIDTH];
    logic [WIDTH-1:0]    opa_d [WIDTH];
    logic [WIDTH-1:0]    opb_q [WIDTH];
    logic [WIDTH-1:0]    opb_d [WIDTH];

    logic [PW-1:0]       mem_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]     mem_id_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    mem_count_q, mem_count_d;
    logic                res_valid_q, res_valid_d;
    logic [PW-1:0]       res_data_q, res_data_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic                push, pop, load;
    logic [PW-1:0]       push_data;
    logic [ID_W-1:0]     push_id;

    // Occupancy counts the output register too, so credit covers every slot a product can land in.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < WIDTH; k++) begin
            inflight = inflight + OCC_W'(tag_vld_q[k]);
        end
        used = inflight + OCC_W'(mem_count_q) + OCC_W'(res_valid_q);
    end

    always_comb begin
        init_d    = 1'b1;
        grant_id  = '0;
        cand      = '0;
        issue     = 1'b0;
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        ptr_d     = ptr_q;
        if (init_q && bus.en && (used < OCC_W'(FIFO_DEPTH))) begin
            // Walk downward so the candidate closest to ptr is the one left standing.
            for (int off = N_REQ - 1; off >= 0; off--) begin
                cand = ID_W'((int'(ptr_q) + off) % N_REQ);
                if (bus.req_valid[cand]) begin
                    issue    = 1'b1;
                    grant_id = cand;
                end
            end
        end
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            mul_a = bus.req_a[grant_id*WIDTH +: WIDTH];
            mul_b = bus.req_b[grant_id*WIDTH +: WIDTH];
            ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant_id;
        for (int k = 1; k < WIDTH; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    // Booth stage k adds (a[k-1] - a[k]) * b * 2^k; a_ext carries the implicit a[-1] = 0.
    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH:0]   a_ext;
        logic [PW-1:0]    acc_src;
        logic [PW-1:0]    b_sh;
        a_src   = '0;
        b_src   = '0;
        a_ext   = '0;
        acc_src = '0;
        b_sh    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k == 0) begin
                a_src   = mul_a;
                b_src   = mul_b;
                acc_src = '0;
            end else begin
                a_src   = opa_q[k-1];
                b_src   = opb_q[k-1];
                acc_src = acc_q[k-1];
            end
            a_ext = {a_src, 1'b0};
            b_sh  = {{WIDTH{b_src[WIDTH-1]}}, b_src} << k;
            acc_d[k] = acc_src;
            case ({a_ext[k+1], a_ext[k]})
                2'b01:   acc_d[k] = acc_src + b_sh;
                2'b10:   acc_d[k] = acc_src - b_sh;
                default: acc_d[k] = acc_src;
            endcase
            opa_d[k] = a_src;
            opb_d[k] = b_src;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            acc_q[k] <= acc_d[k];
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
        end
    end

    assign push      = tag_vld_q[WIDTH-1];
    assign push_id   = tag_id_q[WIDTH-1];
    assign push_data = acc_q[WIDTH-1];

    // The output register is the FIFO head; entries reach it one cycle after landing in storage.
    always_comb begin
        pop         = res_valid_q & bus.res_ready;
        load        = (~res_valid_q | pop) & (mem_count_q != '0);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (load) begin
            rd_ptr_d    = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = mem_data_q[rd_ptr_q];
            res_id_d    = mem_id_q[rd_ptr_q];
        end else if (pop) begin
            res_valid_d = 1'b0;
        end
        case ({push, load})
            2'b10:   mem_count_d = mem_count_q + 1'b1;
            2'b01:   mem_count_d = mem_count_q - 1'b1;
            default: mem_count_d = mem_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_id_q[wr_ptr_q]   <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            ptr_q       <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                tag_id_q[k] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            init_q      <= init_d;
            ptr_q       <= ptr_d;
            tag_vld_q   <= tag_vld_d;
            for (int k = 0; k < WIDTH; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (mem_count_q == CNT_W'(FIFO_DEPTH))));

    assign bus.req_ready = req_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (|tag_vld_q) | (mem_count_q != '0) | res_valid_q;
endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched: operand table plus arbitration, back-pressure,
// reset and enable sequences.
module tb_mult_share_sched;
    logic clk;
    logic rst_n;

    mult_share_sched_if #(.WIDTH(8), .N_REQ(4)) bus ();

    mult_share_sched #(.WIDTH(8), .N_REQ(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rq;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    vec_t        vecs [9];
    logic [7:0]  ta [4];
    logic [7:0]  tbv [4];
    logic [15:0] tp [4];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int oh_err = 0;
    int          acc_ids [$];
    int          res_ids [$];
    logic [15:0] res_dat [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    acc_ids.push_back(i);
                    acc_cyc <= cyc + 1;
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                res_ids.push_back(int'(bus.res_id));
                res_dat.push_back(bus.res_data);
            end
            if ($countones(bus.req_ready) > 1 || (bus.req_ready & ~bus.req_valid) != 4'b0)
                oh_err <= oh_err + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_ids.delete();
        res_ids.delete();
        res_dat.delete();
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic set_ops();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*8 +: 8] = ta[i];
            bus.req_b[i*8 +: 8] = tbv[i];
        end
    endtask

    task automatic wait_acc(input int n, input int bound);
        for (int c = 0; c < bound && acc_ids.size() < n; c++) tick();
    endtask

    task automatic wait_res(input int n, input int bound);
        for (int c = 0; c < bound && res_ids.size() < n; c++) tick();
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int c = 0; c < bound && bus.busy; c++) tick();
        chk(name, bus.busy, 0);
    endtask

    initial begin
        int n0;
        int rise;

        vecs[0] = '{0, 8'h03, 8'hFB, 16'hFFF1};
        vecs[1] = '{1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{2, 8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{3, 8'h00, 8'hFF, 16'h0000};
        vecs[4] = '{0, 8'h7F, 8'h7F, 16'h3F01};
        vecs[5] = '{1, 8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{2, 8'h05, 8'h07, 16'h0023};
        vecs[7] = '{3, 8'hF9, 8'h06, 16'hFFD6};
        vecs[8] = '{1, 8'h64, 8'hFD, 16'hFED4};
        ta[0] = 8'h02; tbv[0] = 8'h03; tp[0] = 16'h0006;
        ta[1] = 8'hFC; tbv[1] = 8'h05; tp[1] = 16'hFFEC;
        ta[2] = 8'h09; tbv[2] = 8'hF7; tp[2] = 16'hFFAF;
        ta[3] = 8'h80; tbv[3] = 8'hFF; tp[3] = 16'h0080;

        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        #22;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_busy", bus.busy, 0);
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // single-requester operand table
        foreach (vecs[v]) begin
            n0 = acc_ids.size();
            bus.req_valid = '0;
            bus.req_valid[vecs[v].rq] = 1'b1;
            bus.req_a[vecs[v].rq*8 +: 8] = vecs[v].a;
            bus.req_b[vecs[v].rq*8 +: 8] = vecs[v].b;
            bus.res_ready = 1'b1;
            for (int c = 0; c < 8 && acc_ids.size() == n0; c++) tick();
            bus.req_valid = '0;
            chk("vec_accept", acc_ids.size(), n0 + 1);
            rise = -1;
            for (int c = 0; c < 20 && rise < 0; c++) begin
                tick();
                if (bus.res_valid) rise = cyc;
            end
            chk("vec_latency", rise - acc_cyc, 9);
            chk("vec_data", bus.res_data, vecs[v].prod);
            chk("vec_id", bus.res_id, vecs[v].rq);
            tick();
            chk("vec_valid_after_pop", bus.res_valid, 0);
            chk("vec_data_hold", bus.res_data, vecs[v].prod);
            chk("vec_busy_after_pop", bus.busy, 0);
        end

        // all requesters valid, consumer always ready: rotating grants, in-order results
        do_reset();
        set_ops();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'hF;
        wait_acc(8, 60);
        bus.req_valid = '0;
        chk("rr_accepts", acc_ids.size(), 8);
        wait_res(8, 100);
        chk("rr_results", res_ids.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < acc_ids.size()) chk("rr_grant", acc_ids[k], k % 4);
            if (k < res_ids.size()) begin
                chk("rr_res_id", res_ids[k], k % 4);
                chk("rr_res_data", res_dat[k], tp[k % 4]);
            end
        end
        wait_idle("rr_idle", 40);

        // back-pressure: credit stops issue at FIFO_DEPTH
        do_reset();
        bus.res_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (20) tick();
        chk("bp_accepts", acc_ids.size(), 4);
        chk("bp_req_ready", bus.req_ready, 0);
        chk("bp_res_valid", bus.res_valid, 1);
        chk("bp_no_pop", res_ids.size(), 0);
        bus.res_ready = 1'b1;
        #1;
        chk("bp_pop_cycle_no_credit", bus.req_ready, 0);
        tick();
        chk("bp_resume_grant", bus.req_ready, 4'b0001);
        tick();
        chk("bp_resume_accept", acc_ids.size(), 5);
        bus.req_valid = '0;
        wait_res(5, 60);
        chk("bp_results", res_ids.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < res_ids.size()) begin
                chk("bp_res_id", res_ids[k], k % 4);
                chk("bp_res_data", res_dat[k], tp[k % 4]);
            end
        end
        wait_idle("bp_idle", 40);

        // reset mid-operation discards buffered and in-flight work
        do_reset();
        bus.res_ready = 1'b0;
        bus.req_valid = 4'hF;
        wait_acc(2, 10);
        bus.req_valid = '0;
        repeat (12) tick();
        chk("mr_buffered", bus.res_valid, 1);
        bus.req_valid = 4'hF;
        wait_acc(4, 10);
        bus.req_valid = '0;
        chk("mr_accepts", acc_ids.size(), 4);
        chk("mr_busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_res_valid_now", bus.res_valid, 0);
        chk("mr_busy_now", bus.busy, 0);
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        clear_q();
        repeat (25) tick();
        chk("mr_no_results", res_ids.size(), 0);
        chk("mr_busy_after", bus.busy, 0);

        // en low: no grants, in-flight products still delivered
        do_reset();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'hF;
        wait_acc(2, 10);
        bus.en = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        chk("en_req_ready_low", bus.req_ready, 0);
        wait_res(2, 30);
        chk("en_results", res_ids.size(), 2);
        chk("en_no_new_accepts", acc_ids.size(), 2);
        for (int k = 0; k < 2; k++) begin
            if (k < res_ids.size()) begin
                chk("en_res_id", res_ids[k], k);
                chk("en_res_data", res_dat[k], tp[k]);
            end
        end
        wait_idle("en_idle", 10);
        bus.en = 1'b1;
        #1;
        chk("en_regrant", bus.req_ready, 4'b0010);
        tick();
        chk("en_accept_count", acc_ids.size(), 3);
        if (acc_ids.size() == 3) chk("en_accept_id", acc_ids[2], 1);
        bus.req_valid = '0;
        wait_idle("en_final_idle", 30);

        chk("grant_onehot", oh_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
